mips_decoder: RTL and testbench

Registered MIPS-I instruction decoder in the processor's decode stage. It classifies a 32-bit instruction word as R-, I- or J-type, extracts its fields, and generates the main datapath control signals. All outputs are registered, with one clock of latency.

---
 rtl/mips_decoder_if.sv | 44 ++++
 rtl/mips_decoder.sv | 223 ++++++++++++++++++++++
 tb/tb_mips_decoder.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mips_decoder_if.sv
// Decode-stage bus: instruction in, registered fields and control signals out.
// The fetch side takes the master modport, the decoder the slave modport.
interface mips_decoder_if;
    logic        ins_valid;
    logic [31:0] ins;
    logic        out_valid;
    logic        r;
    logic        i;
    logic        j;
    logic        illegal;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] imm_ext;
    logic [25:0] target;
    logic        reg_write;
    logic [1:0]  reg_dst;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        branch;
    logic        branch_ne;
    logic        jump;
    logic        jump_reg;
    logic [3:0]  alu_op;

    modport master (
        output ins_valid, ins,
        input  out_valid, r, i, j, illegal, opcode, rs, rt, rd, shamt, funct,
               imm_ext, target, reg_write, reg_dst, alu_src, mem_read, mem_write,
               mem_to_reg, branch, branch_ne, jump, jump_reg, alu_op
    );

    modport slave (
        input  ins_valid, ins,
        output out_valid, r, i, j, illegal, opcode, rs, rt, rd, shamt, funct,
               imm_ext, target, reg_write, reg_dst, alu_src, mem_read, mem_write,
               mem_to_reg, branch, branch_ne, jump, jump_reg, alu_op
    );
endinterface

// File: rtl/mips_decoder.sv
// Registered MIPS-I decoder: classifies R/I/J, slices fields and builds the
// main datapath controls, one clock after the instruction is presented.
module mips_decoder (
    input  logic          clk,
    input  logic          rst,
    mips_decoder_if.slave bus
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef struct packed {
        logic        out_valid;
        logic        r;
        logic        i;
        logic        j;
        logic        illegal;
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [31:0] imm_ext;
        logic [25:0] target;
        logic        reg_write;
        logic [1:0]  reg_dst;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        branch;
        logic        branch_ne;
        logic        jump;
        logic        jump_reg;
        logic [3:0]  alu_op;
    } dec_t;

    // Returns {legal, alu_op} for an R-type funct that computes into rd (jr excluded).
    function automatic logic [4:0] rtype_alu(input logic [5:0] f);
        logic [4:0] res;
        case (f)
            6'h20, 6'h21: res = {1'b1, ALU_ADD};
            6'h22, 6'h23: res = {1'b1, ALU_SUB};
            6'h24:        res = {1'b1, ALU_AND};
            6'h25:        res = {1'b1, ALU_OR};
            6'h26:        res = {1'b1, ALU_XOR};
            6'h27:        res = {1'b1, ALU_NOR};
            6'h2A:        res = {1'b1, ALU_SLT};
            6'h2B:        res = {1'b1, ALU_SLTU};
            6'h00:        res = {1'b1, ALU_SLL};
            6'h02:        res = {1'b1, ALU_SRL};
            6'h03:        res = {1'b1, ALU_SRA};
            default:      res = {1'b0, ALU_ADD};
        endcase
        return res;
    endfunction

    // Returns {legal, alu_op} for the register-writing ALU-immediate opcodes.
    function automatic logic [4:0] imm_alu(input logic [5:0] op);
        logic [4:0] res;
        case (op)
            6'h08, 6'h09: res = {1'b1, ALU_ADD};
            6'h0A:        res = {1'b1, ALU_SLT};
            6'h0B:        res = {1'b1, ALU_SLTU};
            6'h0C:        res = {1'b1, ALU_AND};
            6'h0D:        res = {1'b1, ALU_OR};
            6'h0E:        res = {1'b1, ALU_XOR};
            6'h0F:        res = {1'b1, ALU_LUI};
            default:      res = {1'b0, ALU_ADD};
        endcase
        return res;
    endfunction

    dec_t       w_dec;
    dec_t       r_dec;
    logic [4:0] w_fn_res;
    logic [4:0] w_imm_res;

    // Combinational decode of the presented instruction word.
    always_comb begin
        w_dec           = '0;
        w_dec.out_valid = 1'b1;
        w_dec.opcode    = bus.ins[31:26];
        w_dec.rs        = bus.ins[25:21];
        w_dec.rt        = bus.ins[20:16];
        w_dec.rd        = bus.ins[15:11];
        w_dec.shamt     = bus.ins[10:6];
        w_dec.funct     = bus.ins[5:0];
        w_dec.target    = bus.ins[25:0];
        w_fn_res        = rtype_alu(bus.ins[5:0]);
        w_imm_res       = imm_alu(bus.ins[31:26]);

        // Logical immediates are unsigned; everything else, R/J included, sign-extends.
        if ((w_dec.opcode == OP_ANDI) || (w_dec.opcode == OP_ORI) || (w_dec.opcode == OP_XORI)) begin
            w_dec.imm_ext = {16'h0000, bus.ins[15:0]};
        end else begin
            w_dec.imm_ext = {{16{bus.ins[15]}}, bus.ins[15:0]};
        end

        case (w_dec.opcode)
            OP_RTYPE: begin
                if (w_dec.funct == FN_JR) begin
                    w_dec.r        = 1'b1;
                    w_dec.jump     = 1'b1;
                    w_dec.jump_reg = 1'b1;
                end else if (w_fn_res[4]) begin
                    w_dec.r         = 1'b1;
                    w_dec.reg_write = 1'b1;
                    w_dec.reg_dst   = 2'd1;
                    w_dec.alu_op    = w_fn_res[3:0];
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            OP_J, OP_JAL: begin
                w_dec.j    = 1'b1;
                w_dec.jump = 1'b1;
                if (w_dec.opcode == OP_JAL) begin
                    w_dec.reg_write = 1'b1;
                    w_dec.reg_dst   = 2'd2;
                end else begin
                    w_dec.reg_dst   = 2'd0;
                end
            end
            OP_BEQ, OP_BNE: begin
                w_dec.i         = 1'b1;
                w_dec.branch    = 1'b1;
                w_dec.branch_ne = (w_dec.opcode == OP_BNE);
                w_dec.alu_op    = ALU_SUB;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                w_dec.i          = 1'b1;
                w_dec.alu_src    = 1'b1;
                w_dec.mem_read   = 1'b1;
                w_dec.mem_to_reg = 1'b1;
                w_dec.reg_write  = 1'b1;
                w_dec.alu_op     = ALU_ADD;
            end
            OP_SB, OP_SH, OP_SW: begin
                w_dec.i         = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.mem_write = 1'b1;
                w_dec.alu_op    = ALU_ADD;
            end
            default: begin
                if (w_imm_res[4]) begin
                    w_dec.i         = 1'b1;
                    w_dec.alu_src   = 1'b1;
                    w_dec.reg_write = 1'b1;
                    w_dec.alu_op    = w_imm_res[3:0];
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
        endcase
    end

    // Output register: capture on valid, otherwise only drop out_valid and hold the rest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dec <= '0;
        end else if (bus.ins_valid) begin
            r_dec <= w_dec;
        end else begin
            r_dec.out_valid <= 1'b0;
        end
    end

    assign bus.out_valid  = r_dec.out_valid;
    assign bus.r          = r_dec.r;
    assign bus.i          = r_dec.i;
    assign bus.j          = r_dec.j;
    assign bus.illegal    = r_dec.illegal;
    assign bus.opcode     = r_dec.opcode;
    assign bus.rs         = r_dec.rs;
    assign bus.rt         = r_dec.rt;
    assign bus.rd         = r_dec.rd;
    assign bus.shamt      = r_dec.shamt;
    assign bus.funct      = r_dec.funct;
    assign bus.imm_ext    = r_dec.imm_ext;
    assign bus.target     = r_dec.target;
    assign bus.reg_write  = r_dec.reg_write;
    assign bus.reg_dst    = r_dec.reg_dst;
    assign bus.alu_src    = r_dec.alu_src;
    assign bus.mem_read   = r_dec.mem_read;
    assign bus.mem_write  = r_dec.mem_write;
    assign bus.mem_to_reg = r_dec.mem_to_reg;
    assign bus.branch     = r_dec.branch;
    assign bus.branch_ne  = r_dec.branch_ne;
    assign bus.jump       = r_dec.jump;
    assign bus.jump_reg   = r_dec.jump_reg;
    assign bus.alu_op     = r_dec.alu_op;

endmodule

// File: tb/tb_mips_decoder.sv
// Bench for mips_decoder: table-driven reference model compared every cycle,
// plus literal checks of the documented example instructions.
module tb_mips_decoder;

    typedef struct packed {
        logic        out_valid;
        logic        r;
        logic        i;
        logic        j;
        logic        illegal;
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [31:0] imm_ext;
        logic [25:0] target;
        logic        reg_write;
        logic [1:0]  reg_dst;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        branch;
        logic        branch_ne;
        logic        jump;
        logic        jump_reg;
        logic [3:0]  alu_op;
    } outs_t;

    localparam int K_ILL = 0, K_R = 1, K_ALUI = 2, K_LOAD = 3, K_STORE = 4, K_BR = 5, K_J = 6;
    localparam int FN_BAD = -1, FN_JR = 100;

    logic  clk;
    logic  rst;
    int    n_total;
    int    n_pass;
    int    op_kind [64];
    int    op_alu  [64];
    int    fn_alu  [64];
    outs_t exp_q;
    outs_t act;

    mips_decoder_if bus ();

    mips_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign act = {bus.out_valid, bus.r, bus.i, bus.j, bus.illegal, bus.opcode, bus.rs,
                  bus.rt, bus.rd, bus.shamt, bus.funct, bus.imm_ext, bus.target,
                  bus.reg_write, bus.reg_dst, bus.alu_src, bus.mem_read, bus.mem_write,
                  bus.mem_to_reg, bus.branch, bus.branch_ne, bus.jump, bus.jump_reg,
                  bus.alu_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t model(input logic [31:0] w);
        outs_t o;
        int    op;
        int    fa;
        o           = '0;
        op          = int'(w[31:26]);
        o.out_valid = 1'b1;
        o.opcode    = w[31:26];
        o.rs        = w[25:21];
        o.rt        = w[20:16];
        o.rd        = w[15:11];
        o.shamt     = w[10:6];
        o.funct     = w[5:0];
        o.target    = w[25:0];
        o.imm_ext   = (op >= 12 && op <= 14) ? {16'h0000, w[15:0]} : {{16{w[15]}}, w[15:0]};
        fa          = fn_alu[int'(w[5:0])];
        case (op_kind[op])
            K_R: begin
                if (fa == FN_BAD) o.illegal = 1'b1;
                else if (fa == FN_JR) begin o.r = 1'b1; o.jump = 1'b1; o.jump_reg = 1'b1; end
                else begin o.r = 1'b1; o.reg_write = 1'b1; o.reg_dst = 2'd1; o.alu_op = 4'(fa); end
            end
            K_ALUI: begin o.i = 1'b1; o.alu_src = 1'b1; o.reg_write = 1'b1; o.alu_op = 4'(op_alu[op]); end
            K_LOAD: begin
                o.i = 1'b1; o.alu_src = 1'b1; o.mem_read = 1'b1; o.mem_to_reg = 1'b1; o.reg_write = 1'b1;
            end
            K_STORE: begin o.i = 1'b1; o.alu_src = 1'b1; o.mem_write = 1'b1; end
            K_BR: begin o.i = 1'b1; o.branch = 1'b1; o.branch_ne = (op == 5); o.alu_op = 4'd1; end
            K_J: begin
                o.j = 1'b1; o.jump = 1'b1;
                if (op == 3) begin o.reg_write = 1'b1; o.reg_dst = 2'd2; end
            end
            default: o.illegal = 1'b1;
        endcase
        return o;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) exp_q <= '0;
        else if (bus.ins_valid) exp_q <= model(bus.ins);
        else exp_q.out_valid <= 1'b0;
    end

    always @(negedge clk) begin
        if (!rst) begin
            n_total++;
            if (act === exp_q) n_pass++;
            else $display("FAIL model_cmp: got %h want %h ins=%h", act, exp_q, bus.ins);
        end
    end

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        n_total++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %h want %h", name, a, e);
    endtask

    task automatic send(input logic [31:0] w);
        @(negedge clk);
        bus.ins_valid = 1'b1;
        bus.ins       = w;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_ins();
        logic [5:0] ops [20];
        logic [5:0] fns [14];
        logic [31:0] w;
        int sel;
        ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
                6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h2B};
        fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                6'h00, 6'h02, 6'h03, 6'h08};
        w   = $urandom;
        sel = $urandom_range(0, 9);
        if (sel < 4) w[31:26] = ops[$urandom_range(0, 19)];
        else if (sel < 7) begin w[31:26] = 6'h00; w[5:0] = fns[$urandom_range(0, 13)]; end
        else if (sel == 7) w[31:26] = 6'h29;
        return w;
    endfunction

    initial begin
        n_total = 0;
        n_pass  = 0;
        for (int k = 0; k < 64; k++) begin op_kind[k] = K_ILL; op_alu[k] = 0; fn_alu[k] = FN_BAD; end
        op_kind[0] = K_R; op_kind[2] = K_J; op_kind[3] = K_J;
        op_kind[4] = K_BR; op_kind[5] = K_BR;
        for (int k = 8; k <= 15; k++) op_kind[k] = K_ALUI;
        op_alu[8] = 0; op_alu[9] = 0; op_alu[10] = 6; op_alu[11] = 7;
        op_alu[12] = 2; op_alu[13] = 3; op_alu[14] = 4; op_alu[15] = 11;
        op_kind[32] = K_LOAD; op_kind[33] = K_LOAD; op_kind[35] = K_LOAD;
        op_kind[36] = K_LOAD; op_kind[37] = K_LOAD;
        op_kind[40] = K_STORE; op_kind[41] = K_STORE; op_kind[43] = K_STORE;
        fn_alu[32] = 0; fn_alu[33] = 0; fn_alu[34] = 1; fn_alu[35] = 1;
        fn_alu[36] = 2; fn_alu[37] = 3; fn_alu[38] = 4; fn_alu[39] = 5;
        fn_alu[42] = 6; fn_alu[43] = 7; fn_alu[0] = 8; fn_alu[2] = 9; fn_alu[3] = 10;
        fn_alu[8] = FN_JR;

        rst = 1'b1;
        bus.ins_valid = 1'b0;
        bus.ins = 32'hFFFF_FFFF;
        #3;
        chk("reset_all_zero", {31'd0, act == '0}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_after_reset", {31'd0, act == '0}, 32'd1);

        send(32'h014B4820);
        chk("add.r", bus.r, 32'd1); chk("add.i", bus.i, 32'd0); chk("add.j", bus.j, 32'd0);
        chk("add.rs", bus.rs, 32'd10); chk("add.rt", bus.rt, 32'd11); chk("add.rd", bus.rd, 32'd9);
        chk("add.funct", bus.funct, 32'h20); chk("add.alu_op", bus.alu_op, 32'd0);
        chk("add.reg_write", bus.reg_write, 32'd1); chk("add.reg_dst", bus.reg_dst, 32'd1);
        chk("add.out_valid", bus.out_valid, 32'd1);
        send(32'h23120025);
        chk("addi.i", bus.i, 32'd1); chk("addi.r", bus.r, 32'd0); chk("addi.rs", bus.rs, 32'd24);
        chk("addi.rt", bus.rt, 32'd18); chk("addi.imm", bus.imm_ext, 32'h00000025);
        chk("addi.alu_src", bus.alu_src, 32'd1);
        send(32'h3000FFFF);
        chk("andi.imm_zext", bus.imm_ext, 32'h0000FFFF); chk("andi.alu_op", bus.alu_op, 32'd2);
        send(32'h2000FFFF);
        chk("addi.imm_sext", bus.imm_ext, 32'hFFFFFFFF);
        send(32'h08000000);
        chk("j.j", bus.j, 32'd1); chk("j.jump", bus.jump, 32'd1); chk("j.target", bus.target, 32'd0);
        chk("j.reg_write", bus.reg_write, 32'd0);
        send(32'h0C000010);
        chk("jal.reg_write", bus.reg_write, 32'd1); chk("jal.reg_dst", bus.reg_dst, 32'd2);
        chk("jal.target", bus.target, 32'h10);
        send(32'h8C820004);
        chk("lw.mem_read", bus.mem_read, 32'd1); chk("lw.mem_to_reg", bus.mem_to_reg, 32'd1);
        send(32'hAC820004);
        chk("sw.mem_write", bus.mem_write, 32'd1); chk("sw.reg_write", bus.reg_write, 32'd0);
        send(32'h14220003);
        chk("bne.branch", bus.branch, 32'd1); chk("bne.branch_ne", bus.branch_ne, 32'd1);
        chk("bne.alu_op", bus.alu_op, 32'd1); chk("bne.alu_src", bus.alu_src, 32'd0);
        send(32'h03E00008);
        chk("jr.jump_reg", bus.jump_reg, 32'd1); chk("jr.reg_write", bus.reg_write, 32'd0);
        send(32'hFC000000);
        chk("ill_op.illegal", bus.illegal, 32'd1);
        chk("ill_op.rij", {29'd0, bus.r, bus.i, bus.j}, 32'd0);
        chk("ill_op.opcode", bus.opcode, 32'h3F);
        send(32'h00000001);
        chk("ill_fn.illegal", bus.illegal, 32'd1); chk("ill_fn.alu_op", bus.alu_op, 32'd0);
        @(negedge clk);
        bus.ins_valid = 1'b0;
        bus.ins = 32'h8C820004;
        @(posedge clk);
        #1;
        chk("hold.out_valid", bus.out_valid, 32'd0);
        chk("hold.illegal", bus.illegal, 32'd1);
        chk("hold.funct", bus.funct, 32'd1);

        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            bus.ins_valid = ($urandom_range(0, 4) != 0);
            bus.ins = rand_ins();
            if (k == 1500) begin
                bus.ins_valid = 1'b1;
                #2 rst = 1'b1;
                #1;
                chk("midstream_reset", {31'd0, act == '0}, 32'd1);
                @(negedge clk);
                rst = 1'b0;
            end
        end
        @(negedge clk);
        bus.ins_valid = 1'b0;
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
